// File: rtl/mac_acc_pkg.sv
// ----------------------------------------------------------------------------
// mac_acc_pkg
// Shared definitions for the 24-bit multiply-accumulate block: the default
// widths of the product, accumulator and run-length fields, and the state
// encoding of the accumulator FSM.
// ----------------------------------------------------------------------------
package mac_acc_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_accumulator_24b_sat_add.sv
// ----------------------------------------------------------------------------
// sat_add_24b
// Combinational saturating adder. It adds an unsigned, zero-extended product
// to the accumulator and clamps the result to all ones when the addition
// carries out of ACC_W bits.
//
// Ports
//   acc_in   : current accumulator value (ACC_W)
//   addend   : unsigned product (PROD_W), zero-extended before the add
//   ovf_in   : current sticky overflow flag
//   sum      : saturated sum (ACC_W)
//   carry    : carry out of the ACC_W+1 bit add (1 = sum was clamped)
//   ovf_out  : updated sticky overflow flag (ovf_in | carry)
// ----------------------------------------------------------------------------
module sat_add_24b
    import mac_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] addend,
    input  logic              ovf_in,
    output logic [ACC_W-1:0]  sum,
    output logic              carry,
    output logic              ovf_out
);

    logic [ACC_W:0] wide_sum;

    // The extra top bit holds the carry; anything that lands there means the
    // true sum no longer fits, so the result is pinned at full scale.
    always_comb begin
        wide_sum = {1'b0, acc_in} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        carry    = wide_sum[ACC_W];
        sum      = carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
        ovf_out  = ovf_in | carry;
    end

endmodule

// File: rtl/mac_accumulator_24b.sv
// ----------------------------------------------------------------------------
// mac_accumulator_24b
// Accumulates a run of len+1 unsigned products into a saturating 24-bit
// register, then presents the result with a valid/ready handshake.
//
// Ports
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin a run (only honoured in IDLE)
//   clr        : with start, 1 = clear acc_out/ovf, 0 = continue from them
//   len        : with start, run consumes len+1 products
//   in_valid   : product valid        in_ready  : block accepts a product
//   product    : unsigned product input
//   out_valid  : acc_out is final     out_ready : result consumed downstream
//   acc_out    : registered accumulator value
//   ovf        : sticky saturation flag
//   busy       : high while in ACCUM or DONE
// ----------------------------------------------------------------------------
module mac_accumulator_24b
    import mac_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy
);

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   count;
    logic               xfer;
    logic [ACC_W-1:0]   sat_sum;
    logic               sat_carry;
    logic               sat_ovf;

    sat_add_24b #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc_in  (acc_out),
        .addend  (product),
        .ovf_in  (ovf),
        .sum     (sat_sum),
        .carry   (sat_carry),
        .ovf_out (sat_ovf)
    );

    // Next-state and handshake outputs. The count holds the number of
    // products still to come after the current one, so a transfer seen while
    // it is zero is the last of the run.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                xfer     = in_valid;
                if (in_valid && (count == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator, sticky overflow and remaining-count registers. They only
    // move on a start in IDLE or a transfer in ACCUM; DONE holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= '0;
            ovf     <= 1'b0;
            count   <= '0;
        end else if ((state == IDLE) && start) begin
            count <= len;
            if (clr) begin
                acc_out <= '0;
                ovf     <= 1'b0;
            end
        end else if (xfer) begin
            acc_out <= sat_sum;
            ovf     <= sat_ovf;
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    // Documents which add results were clamped; kept for debug visibility.
    logic unused_carry;
    assign unused_carry = sat_carry;

endmodule

// File: tb/tb_mac_accumulator_24b.sv
// ----------------------------------------------------------------------------
// tb_mac_accumulator_24b
// Directed self-checking bench for mac_accumulator_24b. Inputs change 1 ns
// after each rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_mac_accumulator_24b;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clr;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] acc_out;
    logic        ovf;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mac_accumulator_24b dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue a start request for one cycle.
    task automatic applyStimulus(input logic clr_v, input logic [7:0] len_v);
        start = 1'b1;
        clr   = clr_v;
        len   = len_v;
        tick();
        start = 1'b0;
        clr   = 1'b0;
        len   = 8'd0;
    endtask

    // Offer one product and wait (bounded) until it is accepted.
    task automatic sendOne(input logic [15:0] p);
        logic taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        product  = p;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                taken = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        product  = 16'h0;
        checkOutput("transfer_accepted", {31'd0, taken}, 32'd1);
    endtask

    // Consume the result and return to IDLE.
    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0; len = 8'd0;
        in_valid = 1'b0; product = 16'h0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_acc",       {8'd0, acc_out},      32'h0);
        checkOutput("rst_ovf",       {31'd0, ovf},         32'd0);
        checkOutput("rst_busy",      {31'd0, busy},        32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready},    32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid},   32'd0);

        // Single product run.
        applyStimulus(1'b1, 8'd0);
        checkOutput("single_busy",     {31'd0, busy},     32'd1);
        checkOutput("single_in_ready", {31'd0, in_ready}, 32'd1);
        sendOne(16'hFBC1);
        checkOutput("single_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("single_acc",       {8'd0, acc_out},    32'h00FBC1);
        checkOutput("single_ovf",       {31'd0, ovf},       32'd0);
        checkOutput("single_in_ready_done", {31'd0, in_ready}, 32'd0);
        drain();

        // Run of four with gaps between transfers.
        applyStimulus(1'b1, 8'd3);
        for (int k = 1; k <= 4; k++) begin
            sendOne(16'hFBC1);
            if (k < 4) begin
                tick();
                checkOutput("run4_gap_acc", {8'd0, acc_out}, 32'hFBC1 * k);
                checkOutput("run4_not_done", {31'd0, out_valid}, 32'd0);
            end
        end
        checkOutput("run4_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("run4_acc",       {8'd0, acc_out},    32'h03EF04);
        in_valid = 1'b1; product = 16'h1234;
        tick();
        in_valid = 1'b0;
        checkOutput("run4_no_fifth", {8'd0, acc_out}, 32'h03EF04);
        drain();

        // Saturation and chaining.
        applyStimulus(1'b1, 8'd255);
        for (int k = 0; k < 256; k++) sendOne(16'hFFFF);
        checkOutput("sat_full_run_acc", {8'd0, acc_out},    32'hFFFF00);
        checkOutput("sat_full_run_ovf", {31'd0, ovf},       32'd0);
        checkOutput("sat_full_run_ov",  {31'd0, out_valid}, 32'd1);
        drain();
        applyStimulus(1'b0, 8'd0);
        checkOutput("chain_keep_acc", {8'd0, acc_out}, 32'hFFFF00);
        sendOne(16'h0100);
        checkOutput("sat_acc", {8'd0, acc_out}, 32'hFFFFFF);
        checkOutput("sat_ovf", {31'd0, ovf},    32'd1);
        drain();
        applyStimulus(1'b0, 8'd0);
        sendOne(16'h0000);
        checkOutput("sticky_ovf", {31'd0, ovf},    32'd1);
        checkOutput("sticky_acc", {8'd0, acc_out}, 32'hFFFFFF);
        drain();
        applyStimulus(1'b1, 8'd0);
        checkOutput("clr_acc", {8'd0, acc_out}, 32'h0);
        checkOutput("clr_ovf", {31'd0, ovf},    32'd0);
        sendOne(16'h0005);

        // Backpressure in DONE with start held high.
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; clr = 1'b1; len = 8'd0;
            tick();
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_acc",       {8'd0, acc_out},    32'h5);
            checkOutput("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0; clr = 1'b0;
        checkOutput("bp_release_ov",   {31'd0, out_valid}, 32'd0);
        checkOutput("bp_release_busy", {31'd0, busy},      32'd0);
        checkOutput("bp_release_acc",  {8'd0, acc_out},    32'h5);

        // Reset in the middle of a run.
        applyStimulus(1'b1, 8'd3);
        sendOne(16'h0010);
        sendOne(16'h0010);
        checkOutput("midrun_partial", {8'd0, acc_out}, 32'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrun_rst_acc",      {8'd0, acc_out},   32'h0);
        checkOutput("midrun_rst_busy",     {31'd0, busy},     32'd0);
        checkOutput("midrun_rst_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, 8'd1);
        sendOne(16'h0007);
        sendOne(16'h0008);
        checkOutput("fresh_run_acc", {8'd0, acc_out},    32'hF);
        checkOutput("fresh_run_ov",  {31'd0, out_valid}, 32'd1);
        drain();

        // Start asserted during ACCUM must not restart or shorten the run.
        applyStimulus(1'b1, 8'd3);
        sendOne(16'h0001);
        start = 1'b1; clr = 1'b1; len = 8'd0;
        sendOne(16'h0002);
        start = 1'b0; clr = 1'b0;
        sendOne(16'h0003);
        checkOutput("accum_start_ignored", {31'd0, out_valid}, 32'd0);
        sendOne(16'h0004);
        checkOutput("accum_start_ov",  {31'd0, out_valid}, 32'd1);
        checkOutput("accum_start_acc", {8'd0, acc_out},    32'hA);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
